// File: rtl/debug_pkg.sv
// Shared types and sizing helpers for the debug register dump engine.
package debug_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PC,
    S_SEL,
    S_CAP,
    S_SEND,
    S_CSUM,
    S_DONE
  } dump_state_t;

  localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

  // Bytes carried by one DATA_W-wide word.
  function automatic int unsigned word_bytes(input int unsigned data_w);
    return data_w / 8;
  endfunction

  // Header + PC word + all register words + checksum.
  function automatic int unsigned frame_len(input int unsigned num_regs,
                                            input int unsigned data_w);
    return 1 + (num_regs + 1) * word_bytes(data_w) + 1;
  endfunction

endpackage

// File: rtl/debug_reg_dumper.sv
// Captures PC and all CPU registers through the debug port and streams them
// as a framed, checksummed little-endian byte dump over valid/ready.
module debug_reg_dumper
  import debug_pkg::*;
#(
  parameter int unsigned NUM_REGS      = 16,
  parameter int unsigned SEL_W         = 4,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [7:0]  HDR_BYTE      = HDR_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] fetch_pc,
  output logic [SEL_W-1:0]  debug_reg_select,
  input  logic [DATA_W-1:0] debug_reg_out,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              freeze,
  output logic              busy,
  output logic              done
);

  localparam int unsigned BYTES    = word_bytes(DATA_W);
  localparam int unsigned BYTE_W   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [BYTE_W-1:0]   LAST_BYTE   = BYTE_W'(BYTES - 1);
  localparam logic [SETTLE_W-1:0] LAST_SETTLE = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [SEL_W-1:0]    LAST_REG    = SEL_W'(NUM_REGS - 1);

  dump_state_t         state;
  dump_state_t         state_next;
  logic [DATA_W-1:0]   shift_q;
  logic [BYTE_W-1:0]   byte_idx;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [7:0]          csum_q;
  logic                xfer;
  logic                last_byte;
  logic                last_reg;
  logic                valid_d;
  logic                busy_d;
  logic                done_d;
  logic                busy_q;

  assign xfer      = tx_valid & tx_ready;
  assign last_byte = (byte_idx == LAST_BYTE);
  assign last_reg  = (debug_reg_select == LAST_REG);
  assign busy      = busy_q;
  assign freeze    = busy_q;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic: walk header, PC, each register (select/settle/capture/send), checksum.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = S_HDR;
      S_HDR:  if (xfer) state_next = S_PC;
      S_PC:   if (xfer && last_byte) state_next = S_SEL;
      S_SEL:  if (settle_cnt == LAST_SETTLE) state_next = S_CAP;
      S_CAP:  state_next = S_SEND;
      S_SEND: if (xfer && last_byte) state_next = last_reg ? S_CSUM : S_SEL;
      S_CSUM: if (xfer) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the control outputs come straight from flops.
  always_comb begin
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_next)
      S_HDR, S_PC, S_SEND, S_CSUM: begin
        valid_d = 1'b1;
        busy_d  = 1'b1;
      end
      S_SEL, S_CAP: busy_d = 1'b1;
      S_DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered control outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_valid <= 1'b0;
      busy_q   <= 1'b0;
      done     <= 1'b0;
    end else begin
      tx_valid <= valid_d;
      busy_q   <= busy_d;
      done     <= done_d;
    end
  end

  // Datapath: word shifter, byte/settle counters, register select and running checksum.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q          <= '0;
      byte_idx         <= '0;
      settle_cnt       <= '0;
      csum_q           <= '0;
      tx_data          <= '0;
      debug_reg_select <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          shift_q  <= fetch_pc;
          csum_q   <= '0;
          byte_idx <= '0;
          tx_data  <= HDR_BYTE;
        end
        S_HDR: if (xfer) begin
          tx_data <= shift_q[7:0];
          shift_q <= shift_q >> 8;
        end
        S_PC, S_SEND: if (xfer) begin
          csum_q <= csum_q ^ tx_data;
          if (!last_byte) begin
            tx_data  <= shift_q[7:0];
            shift_q  <= shift_q >> 8;
            byte_idx <= byte_idx + BYTE_W'(1);
          end else begin
            byte_idx   <= '0;
            settle_cnt <= '0;
            if (state == S_PC)  debug_reg_select <= '0;
            else if (!last_reg) debug_reg_select <= debug_reg_select + SEL_W'(1);
            else                tx_data <= csum_q ^ tx_data;
          end
        end
        S_SEL: settle_cnt <= settle_cnt + SETTLE_W'(1);
        S_CAP: begin
          tx_data <= debug_reg_out[7:0];
          shift_q <= debug_reg_out >> 8;
        end
        default: ;
      endcase
    end
  end

endmodule
